mdio_responder: RTL and testbench



---
 rtl/eth_mdio_pkg.sv | 28 ++
 rtl/mdio_responder_if.sv | 26 ++
 rtl/mdio_sync_edge.sv | 49 ++++
 rtl/mdio_responder.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/eth_mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO responder.
// Contents: frame FSM state type, opcode encodings, fixed register
// indices and the preamble length.
package eth_mdio_pkg;

  typedef enum logic [2:0] {
    S_PRE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_RDATA,
    S_WDATA
  } mdio_state_t;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;

  localparam int unsigned PRE_LEN       = 32;
  localparam int unsigned BMSR_LINK_BIT = 2;

endpackage

// File: rtl/mdio_responder_if.sv
// MDIO pin bundle between the MAC management initiator and the PHY-side
// responder.
//   mdc     : management clock driven by the MAC
//   mdio_i  : MDIO pin value as seen by the responder
//   mdio_o  : value the responder drives onto MDIO
//   mdio_oe : responder output enable
interface mdio_responder_if;
  logic mdc;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;

  modport master (
    output mdc,
    output mdio_i,
    input  mdio_o,
    input  mdio_oe
  );

  modport slave (
    input  mdc,
    input  mdio_i,
    output mdio_o,
    output mdio_oe
  );
endinterface

// File: rtl/mdio_sync_edge.sv
// Brings the asynchronous MDIO-side inputs into the clk domain.
// Each input passes through two flops; MDC additionally gets a
// rising-edge detector on its synchronised level.
//   clk, rst_n : system clock, asynchronous active-low reset
//   mdc_a      : raw MDC
//   mdio_a     : raw MDIO input
//   link_a     : raw link status
//   mdc_rise   : one-cycle pulse on a synchronised MDC rising edge
//   mdio_s     : synchronised MDIO input
//   link_s     : synchronised link status
module mdio_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic mdc_a,
  input  logic mdio_a,
  input  logic link_a,
  output logic mdc_rise,
  output logic mdio_s,
  output logic link_s
);

  // bit 0 = mdc, bit 1 = mdio, bit 2 = link
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic       mdc_prev_q, mdc_prev_d;

  always_comb begin
    meta_d     = {link_a, mdio_a, mdc_a};
    sync_d     = meta_q;
    mdc_prev_d = sync_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      mdc_prev_q <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      mdc_prev_q <= mdc_prev_d;
    end
  end

  assign mdc_rise = sync_q[0] & ~mdc_prev_q;
  assign mdio_s   = sync_q[1];
  assign link_s   = sync_q[2];

endmodule

// File: rtl/mdio_responder.sv
// PHY-side Clause-22 MDIO management responder. Oversamples MDC in the
// msoc_clk domain, decodes PRE/ST/OP/PHYAD/REGAD/TA/DATA frames, answers
// reads from a 32x16 register map and reports committed writes.
//   msoc_clk : system clock (at least 8x MDC)
//   rstn     : asynchronous active-low reset
//   mdio     : MDC / MDIO pin bundle (slave side)
//   link_up  : live link status, asynchronous
//   wr_valid : one-cycle pulse when a write frame to this PHY completes
//   wr_reg   : register index of that write
//   wr_data  : data of that write
module mdio_responder
  import eth_mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR  = 5'd1,
  parameter logic [15:0] PHY_ID1   = 16'h0007,
  parameter logic [15:0] PHY_ID2   = 16'hC0F1,
  parameter logic [15:0] BMCR_RST  = 16'h3100,
  parameter logic [15:0] BMSR_CAPS = 16'h7809
) (
  input  logic                   msoc_clk,
  input  logic                   rstn,
  mdio_responder_if.slave        mdio,
  input  logic                   link_up,
  output logic                   wr_valid,
  output logic [4:0]             wr_reg,
  output logic [15:0]            wr_data
);

  localparam logic [5:0] PRE_CNT_MAX = 6'(PRE_LEN);

  logic mdc_rise;
  logic mdio_s;
  logic link_s;

  mdio_sync_edge u_sync (
    .clk      (msoc_clk),
    .rst_n    (rstn),
    .mdc_a    (mdio.mdc),
    .mdio_a   (mdio.mdio_i),
    .link_a   (link_up),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_s),
    .link_s   (link_s)
  );

  mdio_state_t state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] sh_q, sh_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic        wr_valid_q, wr_valid_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] reg0_q, reg0_d;
  logic [15:0] rf_q [4:31];
  logic [15:0] rf_d [4:31];
  logic        latch_q, latch_d;

  logic        phy_match;
  logic        rd_drive;
  logic [4:0]  rd_idx;
  logic [15:0] rd_val;
  logic [15:0] wr_word;

  assign phy_match = (phyad_q == PHY_ADDR);
  assign rd_drive  = phy_match && (op_q == OP_RD);

  // Read value is looked up with the REGAD bit arriving at this E folded
  // in, so it can be loaded on the last REGAD bit.
  always_comb begin
    rd_idx = {regad_q[3:0], mdio_s};
    rd_val = '0;
    case (rd_idx)
      REG_BMCR: rd_val = reg0_q;
      REG_BMSR: begin
        rd_val                = BMSR_CAPS;
        rd_val[BMSR_LINK_BIT] = latch_q;
      end
      REG_ID1:  rd_val = PHY_ID1;
      REG_ID2:  rd_val = PHY_ID2;
      default:  rd_val = rf_q[rd_idx];
    endcase
  end

  assign wr_word = {sh_q[14:0], mdio_s};

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_d       = op_q;
    phyad_d    = phyad_q;
    regad_d    = regad_q;
    sh_d       = sh_q;
    mdio_o_d   = mdio_o_q;
    mdio_oe_d  = mdio_oe_q;
    wr_valid_d = 1'b0;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    reg0_d     = reg0_q;
    rf_d       = rf_q;
    latch_d    = latch_q;

    if (mdc_rise) begin
      case (state_q)
        S_PRE: begin
          if (mdio_s) begin
            if (pre_cnt_q != PRE_CNT_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if (pre_cnt_q == PRE_CNT_MAX) begin
            // This 0 is the first start bit; the count is cleared on the
            // way out so every return to PRE starts from zero.
            state_d   = S_ST;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
        S_ST: begin
          bit_cnt_d = '0;
          state_d   = mdio_s ? S_OP : S_PRE;
          mdio_oe_d = 1'b0;
        end
        S_OP: begin
          op_d = {op_q[0], mdio_s};
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            if (({op_q[0], mdio_s} == OP_RD) || ({op_q[0], mdio_s} == OP_WR)) begin
              state_d = S_PHYAD;
            end else begin
              state_d   = S_PRE;
              mdio_oe_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_PHYAD: begin
          phyad_d = {phyad_q[3:0], mdio_s};
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            state_d   = S_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_REGAD: begin
          regad_d = rd_idx;
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            state_d   = S_TA;
            if (op_q == OP_RD) sh_d = rd_val;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_TA: begin
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
            if (rd_drive) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
            end
          end else begin
            bit_cnt_d = '0;
            if (op_q == OP_RD) begin
              // data[15] goes out here; RDATA then shifts out 14..0 and
              // spends its 16th E releasing the line.
              if (rd_drive) mdio_o_d = sh_q[15];
              sh_d    = {sh_q[14:0], 1'b0};
              state_d = S_RDATA;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b0;
            state_d   = S_PRE;
            if (rd_drive && (regad_q == REG_BMSR)) latch_d = link_s;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (rd_drive) mdio_o_d = sh_q[15];
            sh_d = {sh_q[14:0], 1'b0};
          end
        end
        S_WDATA: begin
          sh_d = wr_word;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            state_d   = S_PRE;
            if (phy_match) begin
              wr_valid_d = 1'b1;
              wr_reg_d   = regad_q;
              wr_data_d  = wr_word;
              case (regad_q)
                REG_BMCR: begin
                  if (wr_word[15]) begin
                    reg0_d  = BMCR_RST;
                    latch_d = 1'b0;
                    for (int unsigned i = 4; i < 32; i++) rf_d[i] = '0;
                  end else begin
                    reg0_d = wr_word;
                  end
                end
                REG_BMSR, REG_ID1, REG_ID2: ;
                default: rf_d[regad_q] = wr_word;
              endcase
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d   = S_PRE;
          pre_cnt_d = '0;
          mdio_oe_d = 1'b0;
        end
      endcase
    end

    // Latched-low: a low link level overrides any load in the same cycle.
    if (!link_s) latch_d = 1'b0;
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_PRE;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      op_q       <= '0;
      phyad_q    <= '0;
      regad_q    <= '0;
      sh_q       <= '0;
      mdio_o_q   <= 1'b0;
      mdio_oe_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      reg0_q     <= BMCR_RST;
      latch_q    <= 1'b0;
      for (int unsigned i = 4; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_q       <= op_d;
      phyad_q    <= phyad_d;
      regad_q    <= regad_d;
      sh_q       <= sh_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oe_q  <= mdio_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      reg0_q     <= reg0_d;
      latch_q    <= latch_d;
      rf_q       <= rf_d;
    end
  end

  assign mdio.mdio_o  = mdio_o_q;
  assign mdio.mdio_oe = mdio_oe_q;
  assign wr_valid     = wr_valid_q;
  assign wr_reg       = wr_reg_q;
  assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: the stimulus process drives MDC/MDIO
// frames and queues expected read words and write reports; one checker
// process samples the DUT on msoc_clk falling edges, reconstructs read
// responses at MDC rising edges (the MAC sample point) and pops/compares.
module tb_mdio_responder;
  import eth_mdio_pkg::*;

  localparam logic [4:0] PHY = 5'd1;

  logic        msoc_clk = 1'b0;
  logic        rstn;
  logic        link_up;
  logic        wr_valid;
  logic [4:0]  wr_reg;
  logic [15:0] wr_data;

  mdio_responder_if ifc ();

  mdio_responder #(
    .PHY_ADDR  (5'd1),
    .PHY_ID1   (16'h0007),
    .PHY_ID2   (16'hC0F1),
    .BMCR_RST  (16'h3100),
    .BMSR_CAPS (16'h7809)
  ) dut (
    .msoc_clk (msoc_clk),
    .rstn     (rstn),
    .mdio     (ifc),
    .link_up  (link_up),
    .wr_valid (wr_valid),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data)
  );

  always #5 msoc_clk = ~msoc_clk;

  int unsigned n_assert  = 0;
  int unsigned n_fail    = 0;
  int unsigned n_rd_exp  = 0;
  int unsigned n_resp    = 0;
  logic [15:0] rd_q [$];
  logic [20:0] wr_q [$];
  bit          done      = 1'b0;
  bit          rst_mid   = 1'b0;

  // ---------------- stimulus ----------------
  task automatic mdc_bit(input logic b);
    ifc.mdio_i = b;
    ifc.mdc    = 1'b0;
    #50;
    ifc.mdc    = 1'b1;
    #50;
  endtask

  task automatic frame(input int unsigned npre, input logic [1:0] op,
                       input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input int unsigned ntail);
    logic [13:0] hdr;
    logic [17:0] tail;
    hdr  = {2'b01, op, pa, ra};
    tail = (op == OP_WR) ? {2'b10, wd} : '1;
    for (int unsigned i = 0; i < npre; i++) mdc_bit(1'b1);
    for (int i = 13; i >= 0; i--) mdc_bit(hdr[i]);
    for (int unsigned i = 0; i < ntail; i++) mdc_bit(tail[17 - i]);
  endtask

  task automatic rd_frame(input logic [4:0] ra, input logic [15:0] exp);
    rd_q.push_back(exp);
    n_rd_exp++;
    frame(32, OP_RD, PHY, ra, 16'h0000, 18);
  endtask

  task automatic wr_frame(input logic [4:0] ra, input logic [15:0] d);
    wr_q.push_back({ra, d});
    frame(32, OP_WR, PHY, ra, d, 18);
  endtask

  initial begin
    rstn       = 1'b0;
    link_up    = 1'b1;
    ifc.mdc    = 1'b0;
    ifc.mdio_i = 1'b1;
    #32;
    rstn = 1'b1;

    rd_frame(5'd2, 16'h0007);
    wr_frame(5'd5, 16'hA5C3);
    rd_frame(5'd5, 16'hA5C3);

    frame(32, OP_RD, 5'd2, 5'd2, 16'h0000, 18);   // other PHY: silent
    rd_frame(5'd2, 16'h0007);
    frame(31, OP_RD, PHY, 5'd2, 16'h0000, 18);    // short preamble: silent
    frame(32, 2'b11, PHY, 5'd2, 16'h0000, 18);    // bad opcode: silent
    rd_frame(5'd3, 16'hC0F1);

    link_up = 1'b0;
    #200;
    link_up = 1'b1;
    #200;
    rd_frame(5'd1, 16'h7809);
    rd_frame(5'd1, 16'h780D);

    wr_frame(5'd2, 16'hFFFF);
    rd_frame(5'd2, 16'h0007);
    wr_frame(5'd0, 16'h1200);
    rd_frame(5'd0, 16'h1200);
    wr_frame(5'd0, 16'h8000);
    rd_frame(5'd0, 16'h3100);
    rd_frame(5'd5, 16'h0000);
    rd_frame(5'd1, 16'h7809);

    wr_frame(5'd7, 16'h1234);
    rd_frame(5'd7, 16'h1234);
    frame(32, OP_RD, PHY, 5'd7, 16'h0000, 8);     // cut off inside read data
    #4;
    rst_mid = 1'b1;
    rstn    = 1'b0;
    ifc.mdc = 1'b0;
    #40;
    rstn    = 1'b1;
    rst_mid = 1'b0;
    #46;
    rd_frame(5'd7, 16'h0000);
    rd_frame(5'd0, 16'h3100);

    frame(32, OP_WR, 5'd3, 5'd9, 16'hBEEF, 18);   // other PHY: no commit
    rd_frame(5'd9, 16'h0000);

    mdc_bit(1'b1);
    mdc_bit(1'b1);
    #100;
    done = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  bit          rst_seen = 1'b0;
  logic        mdc_prev = 1'b0;
  logic        oe_prev  = 1'b0;
  logic        wr_prev  = 1'b0;
  int unsigned phase    = 0;
  int unsigned cnt      = 0;
  logic [15:0] word     = '0;

  always @(negedge msoc_clk) begin
    if (!rstn) begin
      if (!rst_seen) begin
        rst_seen = 1'b1;
        if (rst_mid) chk("oe_before_reset", 32'(oe_prev), 32'd1);
        chk("rst_mdio_oe", 32'(ifc.mdio_oe), 32'd0);
        chk("rst_mdio_o", 32'(ifc.mdio_o), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_reg", 32'(wr_reg), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
      end
      phase   = 0;
      wr_prev = 1'b0;
    end else begin
      rst_seen = 1'b0;

      if (wr_valid) begin
        chk("wr_pulse_width", 32'(wr_prev), 32'd0);
        if (wr_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected none", wr_reg, wr_data);
        end else begin
          chk("write_port", {11'd0, wr_reg, wr_data}, {11'd0, wr_q.pop_front()});
        end
      end
      wr_prev = wr_valid;

      if (ifc.mdc && !mdc_prev) begin
        case (phase)
          0: if (ifc.mdio_oe) begin
            chk("ta_zero", 32'(ifc.mdio_o), 32'd0);
            phase = 1;
            cnt   = 0;
            word  = '0;
          end
          1: begin
            chk("oe_during_data", 32'(ifc.mdio_oe), 32'd1);
            word = {word[14:0], ifc.mdio_o};
            cnt++;
            if (cnt == 16) phase = 2;
          end
          default: begin
            chk("oe_release", 32'(ifc.mdio_oe), 32'd0);
            n_resp++;
            if (rd_q.size() == 0) begin
              n_assert++;
              n_fail++;
              $display("FAIL unexpected_read: got 0x%0h, expected no response", word);
            end else begin
              chk("read_data", 32'(word), 32'(rd_q.pop_front()));
            end
            phase = 0;
          end
        endcase
      end

      if (done) begin
        chk("read_count", n_resp, n_rd_exp);
        chk("pending_reads", 32'(rd_q.size()), 32'd0);
        chk("pending_writes", 32'(wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
      end
    end
    mdc_prev = ifc.mdc;
    oe_prev  = ifc.mdio_oe;
  end

endmodule
